// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared opcodes, FSM state encoding and size defaults for the mcpu issue slice
//
// Contents:
//   CMD_SIZE_DEF / WORD_SIZE_DEF  default command and word widths (the ALU uses the same values)
//   OP_*                          ALU opcode constants
//   state_t                       issue FSM states
//   op_writes_cf()                1 for opcodes whose carry updates the architectural flag
package mcpu_pkg;

    localparam int CMD_SIZE_DEF  = 3;
    localparam int WORD_SIZE_DEF = 16;
    localparam int NUM_REGS      = 8;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_LSL = 3'd4;
    localparam logic [2:0] OP_LSR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB_LO,
        ST_WB_HI
    } state_t;

    // Logic ops leave the carry flag alone; arithmetic and shifts load it.
    function automatic logic op_writes_cf(input logic [2:0] op);
        return !(op == OP_AND || op == OP_OR || op == OP_XOR);
    endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// rtl/mcpu_regfile.sv - 8-entry register file, two operand read ports, debug read port, arbitrated write
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset (clears R0..R7)
//   ra1/rd1, ra2/rd2        combinational operand read ports
//   dbg_raddr/dbg_rdata     combinational debug read port
//   wb_en/wb_addr/wb_data   ALU writeback
//   ld_en/ld_addr/ld_data   direct load; loses to a writeback targeting the same register
module mcpu_regfile
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           ra1,
    input  logic [2:0]           ra2,
    output logic [WORD_SIZE-1:0] rd1,
    output logic [WORD_SIZE-1:0] rd2,
    input  logic [2:0]           dbg_raddr,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    input  logic                 wb_en,
    input  logic [2:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 ld_en,
    input  logic [2:0]           ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data
);

    logic [WORD_SIZE-1:0] regs [NUM_REGS];

    // Arbitration is per register, so a load to a different register
    // still lands in the same cycle as a writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en && wb_addr == 3'(i))
                    regs[i] <= wb_data;
                else if (ld_en && ld_addr == 3'(i))
                    regs[i] <= ld_data;
            end
        end
    end

    assign rd1       = regs[ra1];
    assign rd2       = regs[ra2];
    assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/mcpu_alu_issue.sv
// rtl/mcpu_alu_issue.sv - single-issue ALU sequencer: accept, drive ALU, wait, write back
//
// Optional feature macro: MCPU_DIV_ZERO_TRAP_EN (DIV by zero traps into sticky div0_err
// instead of writing back; when undefined div0_err is tied 0).
//
// Parameters: CMD_SIZE (>= 3), WORD_SIZE, ALU_WAIT (1..7 settle cycles)
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   instr_valid/instr_ready              instruction handshake (ready only in IDLE)
//   instr_cmd, instr_rd/rs1/rs2          opcode and register indices
//   ld_en, ld_addr, ld_data              direct register load
//   alu_cmd, alu_in1, alu_in2            registered ALU drive, stable through WAIT
//   alu_out, alu_cf                      ALU result (double width) and carry
//   cf_flag, div0_err                    architectural carry, sticky divide-by-zero
//   dbg_raddr/dbg_rdata                  combinational register read
module mcpu_alu_issue
    import mcpu_pkg::*;
#(
    parameter int CMD_SIZE  = CMD_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ALU_WAIT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [CMD_SIZE-1:0]    instr_cmd,
    input  logic [2:0]             instr_rd,
    input  logic [2:0]             instr_rs1,
    input  logic [2:0]             instr_rs2,
    input  logic                   ld_en,
    input  logic [2:0]             ld_addr,
    input  logic [WORD_SIZE-1:0]   ld_data,
    output logic [CMD_SIZE-1:0]    alu_cmd,
    output logic [WORD_SIZE-1:0]   alu_in1,
    output logic [WORD_SIZE-1:0]   alu_in2,
    input  logic [2*WORD_SIZE-1:0] alu_out,
    input  logic                   alu_cf,
    output logic                   cf_flag,
    output logic                   div0_err,
    input  logic [2:0]             dbg_raddr,
    output logic [WORD_SIZE-1:0]   dbg_rdata
);

    state_t               state_q, state_d;
    logic [CMD_SIZE-1:0]  cmd_q;
    logic [2:0]           rd_q, rs1_q, rs2_q;
    logic [2:0]           wait_cnt_q;
    logic [2:0]           op;
    logic                 wait_done;
    logic                 div0_trap;
    logic [WORD_SIZE-1:0] op1, op2;
    logic                 wb_en;
    logic [2:0]           wb_addr;
    logic [WORD_SIZE-1:0] wb_data;

    assign op        = cmd_q[2:0];
    assign wait_done = (wait_cnt_q == 3'(ALU_WAIT - 1));

`ifdef MCPU_DIV_ZERO_TRAP_EN
    assign div0_trap = (op == OP_DIV) && (op2 == '0);
`else
    assign div0_trap = 1'b0;
`endif

    mcpu_regfile #(.WORD_SIZE(WORD_SIZE)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (rs1_q),
        .ra2       (rs2_q),
        .rd1       (op1),
        .rd2       (op2),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = rd_q;
        wb_data     = alu_out[WORD_SIZE-1:0];
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = div0_trap ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (wait_done) state_d = ST_WB_LO;
            ST_WB_LO: begin
                wb_en   = 1'b1;
                state_d = (op == OP_MUL) ? ST_WB_HI : ST_IDLE;
            end
            ST_WB_HI: begin
                // 3-bit add wraps R7 onto R0 for the high product half.
                wb_en   = 1'b1;
                wb_addr = rd_q + 3'd1;
                wb_data = alu_out[2*WORD_SIZE-1:WORD_SIZE];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            wait_cnt_q <= '0;
            alu_cmd    <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            cf_flag    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && instr_valid) begin
                cmd_q <= instr_cmd;
                rd_q  <= instr_rd;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
            end
            // Operands are captured here, before any writeback of this
            // instruction, so rs == rd reads the old value.
            if (state_q == ST_ISSUE && !div0_trap) begin
                alu_cmd <= cmd_q;
                alu_in1 <= op1;
                alu_in2 <= op2;
            end
            if (state_q == ST_WAIT)
                wait_cnt_q <= wait_done ? '0 : wait_cnt_q + 3'd1;
            if (state_q == ST_WB_LO && op_writes_cf(op))
                cf_flag <= alu_cf;
        end
    end

`ifdef MCPU_DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             div0_err <= 1'b0;
        else if (state_q == ST_ISSUE && div0_trap) div0_err <= 1'b1;
    end
`else
    assign div0_err = 1'b0;
`endif

endmodule
